// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if
//   Bundles the issue, ALU-result and output-stream signals of the
//   ALU result collector.
//   master : the surrounding pipeline. It issues operations, supplies the
//            registered ALU result and flags, and consumes collected results.
//   slave  : the collector itself.
//   Signals:
//     issue_valid/issue_tag/issue_ready  operation issue handshake
//     flush                              synchronous discard of all results
//     alu_result/alu_carry/zero/sign     registered ALU outputs
//     out_valid/out_ready                result stream handshake
//     out_tag/out_result/out_flags       head entry ({carry, zero, sign})
//     occupancy                          number of buffered entries
interface alu_result_collector_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              issue_valid;
    logic [TAG_W-1:0]  issue_tag;
    logic              issue_ready;
    logic              flush;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_sign;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [WIDTH-1:0]  out_result;
    logic [2:0]        out_flags;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output issue_valid, issue_tag, flush,
               alu_result, alu_carry, alu_zero, alu_sign, out_ready,
        input  issue_ready, out_valid, out_tag, out_result, out_flags, occupancy
    );

    modport slave (
        input  issue_valid, issue_tag, flush,
               alu_result, alu_carry, alu_zero, alu_sign, out_ready,
        output issue_ready, out_valid, out_tag, out_result, out_flags, occupancy
    );
endinterface

// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Tracks operations issued to a fixed-latency registered ALU. When each
//   result emerges, it is paired with that operation's tag. Results are
//   buffered in a small FIFO until a consumer accepts them.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - alu_result_collector_if.slave (issue, ALU result, output stream)
//   Parameters: WIDTH (result width), DEPTH (FIFO entries, power of two),
//               LATENCY (issue edge to capture edge, >= 1), TAG_W (tag width).
module alu_result_collector #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input logic clk,
    input logic rst,
    alu_result_collector_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] result;
        logic [2:0]       flags;
    } entry_t;

    logic [LATENCY-1:0] dl_valid;
    logic [TAG_W-1:0]   dl_tag [LATENCY];
    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   inflight;
    logic               issue_ready_int;
    logic               out_valid_int;
    logic               issue_acc;
    logic               capture;
    logic               pop;

    // Credit: every in-flight operation already owns a FIFO slot. As a
    // result, a capture can never land in a full FIFO. This decision
    // depends only on registers, so it has no path from
    // issue_valid or out_ready.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(dl_valid[i]);
        end
        issue_ready_int = !rst && ((CNT_W'(occ) + inflight) < CNT_W'(DEPTH));
    end

    // Flush discards the issue, capture and pop that coincide with it.
    always_comb begin
        out_valid_int = (occ != '0);
        issue_acc     = bus.issue_valid && issue_ready_int && !bus.flush;
        capture       = dl_valid[LATENCY-1] && !bus.flush;
        pop           = out_valid_int && bus.out_ready && !bus.flush;
    end

    // Delay line of {valid, tag}. It mirrors the ALU pipeline, so the
    // last stage marks the edge at which alu_result belongs to that tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag[i] <= '0;
            end
        end else if (bus.flush) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= issue_acc;
            dl_tag[0]   <= bus.issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_tag[i]   <= dl_tag[i-1];
            end
        end
    end

    // FIFO bookkeeping. The pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({capture, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage has no reset. Outputs are masked while the FIFO is empty,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= '{tag:    dl_tag[LATENCY-1],
                             result: bus.alu_result,
                             flags:  {bus.alu_carry, bus.alu_zero, bus.alu_sign}};
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        if (!out_valid_int) begin
            head = '0;
        end
    end

    assign bus.issue_ready = issue_ready_int;
    assign bus.out_valid   = out_valid_int;
    assign bus.out_tag     = head.tag;
    assign bus.out_result  = head.result;
    assign bus.out_flags   = head.flags;
    assign bus.occupancy   = occ;
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector
//   Directed, table-driven bench for alu_result_collector (WIDTH=32,
//   DEPTH=4, LATENCY=2, TAG_W=4). Each record holds the inputs for one clock
//   edge and the outputs expected just after that edge. The ALU result is
//   driven in the cycle that ends at edge issue+2. Flush and mid-stream
//   reset are exercised as hand-written sequences.
module tb_alu_result_collector;
    typedef struct {
        string       name;
        logic        iv;
        logic [3:0]  itag;
        logic [31:0] res;
        logic [2:0]  flg;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [3:0]  etag;
        logic [31:0] eres;
        logic [2:0]  eflg;
        logic [2:0]  eocc;
        logic        erdy;
    } vec_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFail;
    vec_t vecs[$];

    alu_result_collector_if #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) bus ();

    alu_result_collector #(.WIDTH(32), .DEPTH(4), .LATENCY(2), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic iv, logic [3:0] it, logic [31:0] r,
                                logic [2:0] f, logic ordy, logic fl, logic eov,
                                logic [3:0] et, logic [31:0] er, logic [2:0] ef,
                                logic [2:0] eo, logic erdy);
        vec_t v;
        v.name = n;  v.iv = iv;    v.itag = it; v.res = r;  v.flg = f;
        v.ordy = ordy; v.fl = fl;  v.eov = eov; v.etag = et;
        v.eres = er; v.eflg = ef;  v.eocc = eo; v.erdy = erdy;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.issue_valid = v.iv;
        bus.issue_tag   = v.itag;
        bus.alu_result  = v.res;
        bus.alu_carry   = v.flg[2];
        bus.alu_zero    = v.flg[1];
        bus.alu_sign    = v.flg[0];
        bus.out_ready   = v.ordy;
        bus.flush       = v.fl;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField({v.name, ".out_valid"}, 32'(bus.out_valid), 32'(v.eov));
        checkField({v.name, ".occupancy"}, 32'(bus.occupancy), 32'(v.eocc));
        checkField({v.name, ".issue_ready"}, 32'(bus.issue_ready), 32'(v.erdy));
        if (v.eov) begin
            checkField({v.name, ".out_tag"}, 32'(bus.out_tag), 32'(v.etag));
            checkField({v.name, ".out_result"}, bus.out_result, v.eres);
            checkField({v.name, ".out_flags"}, 32'(bus.out_flags), 32'(v.eflg));
        end
    endtask

    // One edge: drive inputs, clock, then sample 1 ns after the edge.
    task automatic stepCheck(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(v);
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        rst     = 1'b1;
        applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #1;
        checkField("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkField("reset.occupancy", 32'(bus.occupancy), 32'd0);
        checkField("reset.issue_ready", 32'(bus.issue_ready), 32'd0);
        checkField("reset.out_tag", 32'(bus.out_tag), 32'd0);
        checkField("reset.out_result", bus.out_result, 32'd0);
        checkField("reset.out_flags", 32'(bus.out_flags), 32'd0);
        rst = 1'b0;
        #1;
        checkField("post_reset.issue_ready", 32'(bus.issue_ready), 32'd1);

        //          name   iv tag res          flg     rdy fl  eov etag eres         eflg    occ rdy
        // Single operation
        vecs.push_back(mk("A0", 1, 3, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("A1", 0, 0, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("A2", 0, 0, 32'h5,       3'b000, 0, 0, 1, 3,  32'h5,       3'b000, 1, 1));
        vecs.push_back(mk("A3", 0, 0, 0,           3'b000, 1, 0, 0, 0,  0,           3'b000, 0, 1));
        // Back-to-back fill to DEPTH. B4 issues while not ready (tag 9 must vanish).
        vecs.push_back(mk("B0", 1, 1, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("B1", 1, 2, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("B2", 1, 3, 32'h11,      3'b100, 0, 0, 1, 1,  32'h11,      3'b100, 1, 1));
        vecs.push_back(mk("B3", 1, 4, 32'h22,      3'b010, 0, 0, 1, 1,  32'h11,      3'b100, 2, 0));
        vecs.push_back(mk("B4", 1, 9, 32'h33,      3'b001, 0, 0, 1, 1,  32'h11,      3'b100, 3, 0));
        vecs.push_back(mk("B5", 0, 0, 32'h44,      3'b111, 0, 0, 1, 1,  32'h11,      3'b100, 4, 0));
        vecs.push_back(mk("B6", 0, 0, 32'hDEAD,    3'b111, 0, 0, 1, 1,  32'h11,      3'b100, 4, 0));
        vecs.push_back(mk("B7", 0, 0, 0,           3'b000, 1, 0, 1, 2,  32'h22,      3'b010, 3, 1));
        vecs.push_back(mk("B8", 0, 0, 0,           3'b000, 1, 0, 1, 3,  32'h33,      3'b001, 2, 1));
        vecs.push_back(mk("B9", 0, 0, 0,           3'b000, 1, 0, 1, 4,  32'h44,      3'b111, 1, 1));
        vecs.push_back(mk("B10",0, 0, 0,           3'b000, 1, 0, 0, 0,  0,           3'b000, 0, 1));
        // Credit stall (3 buffered + 1 in flight), then capture+pop at occupancy 3
        vecs.push_back(mk("C0", 1, 5, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("C1", 1, 6, 0,           3'b000, 0, 0, 0, 0,  0,           3'b000, 0, 1));
        vecs.push_back(mk("C2", 1, 7, 32'h55,      3'b000, 0, 0, 1, 5,  32'h55,      3'b000, 1, 1));
        vecs.push_back(mk("C3", 1, 8, 32'h66,      3'b100, 0, 0, 1, 5,  32'h55,      3'b000, 2, 0));
        vecs.push_back(mk("C4", 0, 0, 32'h77,      3'b010, 0, 0, 1, 5,  32'h55,      3'b000, 3, 0));
        vecs.push_back(mk("C5", 0, 0, 32'h88,      3'b001, 1, 0, 1, 6,  32'h66,      3'b100, 3, 1));
        vecs.push_back(mk("C6", 1, 10, 0,          3'b000, 0, 0, 1, 6,  32'h66,      3'b100, 3, 0));
        vecs.push_back(mk("C7", 0, 0, 0,           3'b000, 1, 0, 1, 7,  32'h77,      3'b010, 2, 1));
        vecs.push_back(mk("C8", 0, 0, 32'hAA,      3'b011, 1, 0, 1, 8,  32'h88,      3'b001, 2, 1));
        vecs.push_back(mk("C9", 0, 0, 0,           3'b000, 1, 0, 1, 10, 32'hAA,      3'b011, 1, 1));
        vecs.push_back(mk("C10",0, 0, 0,           3'b000, 1, 0, 0, 0,  0,           3'b000, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            stepCheck(vecs[i]);
        end

        // Flush with 2 buffered and 2 in flight. The issue, pop and capture
        // at the flush edge are lost, and nothing arrives afterwards.
        stepCheck(mk("F0", 1, 1, 0,      3'b000, 0, 0, 0, 0, 0,      3'b000, 0, 1));
        stepCheck(mk("F1", 1, 2, 0,      3'b000, 0, 0, 0, 0, 0,      3'b000, 0, 1));
        stepCheck(mk("F2", 1, 3, 32'h101, 3'b000, 0, 0, 1, 1, 32'h101, 3'b000, 1, 1));
        stepCheck(mk("F3", 1, 4, 32'h202, 3'b100, 0, 0, 1, 1, 32'h101, 3'b000, 2, 0));
        stepCheck(mk("F4", 1, 15, 32'h303, 3'b010, 1, 1, 0, 0, 0,     3'b000, 0, 1));
        stepCheck(mk("F5", 0, 0, 32'h404, 3'b001, 0, 0, 0, 0, 0,      3'b000, 0, 1));
        stepCheck(mk("F6", 0, 0, 32'h505, 3'b111, 0, 0, 0, 0, 0,      3'b000, 0, 1));

        // Asynchronous reset mid-stream with 2 buffered and 1 in flight
        stepCheck(mk("R0", 1, 4'hA, 0,     3'b000, 0, 0, 0, 0,    0,     3'b000, 0, 1));
        stepCheck(mk("R1", 1, 4'hB, 0,     3'b000, 0, 0, 0, 0,    0,     3'b000, 0, 1));
        stepCheck(mk("R2", 1, 4'hC, 32'h1A, 3'b100, 0, 0, 1, 4'hA, 32'h1A, 3'b100, 1, 1));
        stepCheck(mk("R3", 0, 0,   32'h2B, 3'b010, 0, 0, 1, 4'hA, 32'h1A, 3'b100, 2, 1));
        #2;
        rst = 1'b1;
        #1;
        checkField("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
        checkField("async_rst.occupancy", 32'(bus.occupancy), 32'd0);
        checkField("async_rst.issue_ready", 32'(bus.issue_ready), 32'd0);
        checkField("async_rst.out_result", bus.out_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkField("rst_release.issue_ready", 32'(bus.issue_ready), 32'd1);
        stepCheck(mk("R4", 0, 0, 32'h3C, 3'b001, 0, 0, 0, 0, 0, 3'b000, 0, 1));
        stepCheck(mk("R5", 0, 0, 32'h4D, 3'b111, 0, 0, 0, 0, 0, 3'b000, 0, 1));

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end
endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of the captured ALU result.
REQ-002 Parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 Parameter LATENCY, default 2, clock edges from operand sampling at the ALU to the edge at which its registered result is captured here.
REQ-004 Parameter TAG_W, default 4, width of the operation tag.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 issue_valid  input  1  an operation is presented to the ALU this cycle.
REQ-008 issue_tag  input  TAG_W  tag of the presented operation.
REQ-009 issue_ready  output  1  collector has room for one more operation.
REQ-010 flush  input  1  synchronous discard of all in-flight and buffered results.
REQ-011 alu_result  input  WIDTH  registered ALU result.
REQ-012 alu_carry, alu_zero, alu_sign  input  1 each  registered ALU flags.
REQ-013 out_valid  output  1  FIFO head is valid.
REQ-014 out_ready  input  1  consumer accepts the head this cycle.
REQ-015 out_tag  output  TAG_W  tag of the head entry.
REQ-016 out_result  output  WIDTH  result of the head entry.
REQ-017 out_flags  output  3  {carry, zero, sign} of the head entry.
REQ-018 occupancy  output  clog2(DEPTH+1)  number of valid FIFO entries.

Function
REQ-019 An issue is accepted at an edge where issue_valid=1 and issue_ready=1; the upstream SHALL drive the ALU opcode/operands in the same cycle.
REQ-020 Each accepted issue enters a LATENCY-stage delay line of {valid, tag}; a non-accepted cycle inserts a bubble (valid=0).
REQ-021 At the edge where the last delay stage holds valid=1, {tag, alu_result, alu_carry, alu_zero, alu_sign} is written to the FIFO tail (issue at edge k -> capture at edge k+LATENCY).
REQ-022 issue_ready = (occupancy + in-flight count) < DEPTH, computed from registered state only (no combinational path from out_ready or issue_valid).
REQ-023 The credit rule guarantees no capture into a full FIFO; capture and pop are never dropped.
REQ-024 Pop occurs at an edge with out_valid=1 and out_ready=1; head advances, occupancy decrements.
REQ-025 Simultaneous capture and pop: occupancy unchanged, both take effect, legal at any occupancy including DEPTH.
REQ-026 out_valid = (occupancy != 0); out_tag/out_result/out_flags show the head entry, held stable while out_valid=1 and out_ready=0.
REQ-027 Earliest out_valid is the cycle after edge k+LATENCY (no bypass from ALU inputs to outputs).
REQ-028 FIFO pointers wrap modulo DEPTH; entries leave in capture order, which equals issue order.
REQ-029 flush=1 at an edge: all delay-line valid bits and occupancy cleared, pointers reset; issue, capture and pop at that edge are discarded; issue_ready=1 the following cycle.

Reset
REQ-030 While rst=1: delay line invalid, occupancy=0, pointers 0, out_valid=0, out_tag/out_result/out_flags=0, issue_ready=0.
REQ-031 issue_ready=1 from the first cycle after rst deasserts; reset mid-operation discards all in-flight and buffered results.

Verification
REQ-032 Single op: issue tag=3 at edge k, ALU result 0x0000_0005 flags 000 valid for edge k+2 -> out_valid=1 after edge k+2, out_tag=3, out_result=5, out_flags=000.
REQ-033 Back-to-back: issue tags 1..4 on four consecutive edges, out_ready=0 -> occupancy reaches 4, issue_ready=0 after fourth issue, outputs popped in order 1,2,3,4.
REQ-034 Credit stall: 3 entries buffered + 1 in flight, out_ready=0 -> issue_ready=0; assert out_ready one cycle -> issue_ready=1 next cycle.
REQ-035 Full + simultaneous: occupancy=3, one capture and one pop at same edge -> occupancy stays 3, head advances, new entry at tail.
REQ-036 Flush: 2 buffered + 2 in flight, flush=1 one edge -> occupancy=0, out_valid=0, no late captures at the next two edges.
REQ-037 Reset mid-stream: rst asserted asynchronously with occupancy=2 -> out_valid=0 and occupancy=0 immediately, before next clock edge.
